inst_loader: RTL and testbench



---
 rtl/inst_loader.sv | 143 ++++++++++++++
 tb/tb_inst_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into 32-bit RAM writes
// and holds the CPU in reset while loading. Define INST_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module inst_loader #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_CHECK, S_DATA, S_WRITE, S_FINISH, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] idx;
    logic [1:0]       bcnt;
    logic [23:0]      word;
    logic             take;
    logic             last_word;
    logic             too_long;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign take      = byte_valid && byte_ready;
    // Compared one bit wider so idx+1 can never wrap back onto a small length.
    assign last_word = ({1'b0, idx} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, len};
    assign too_long  = len > CNT_W'(MAX_WORDS);

    // NOTE: every output and next-state value gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_rst    = 1'b1;
        busy       = 1'b1;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_rst = 1'b0;
                busy    = 1'b0;
                if (start) state_nxt = S_LEN0;
            end
            S_LEN0: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (len == '0)    state_nxt = S_IDLE;
                else if (too_long) state_nxt = S_ERR;
                else               state_nxt = S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && bcnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = last_word ? S_FINISH : S_DATA;
            end
            S_FINISH: begin
`ifdef INST_LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = (byte_data == csum) ? S_IDLE : S_ERR;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) state_nxt = S_LEN0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            idx      <= '0;
            bcnt     <= '0;
            word     <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            done     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE || state == S_ERR) && start) begin
                done <= 1'b0;
                idx  <= '0;
                bcnt <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (take) begin
                case (state)
                    S_LEN0: len <= CNT_W'(byte_data);
                    S_LEN1: len <= CNT_W'({byte_data, len[7:0]});
                    S_DATA: begin
                        // Little-endian: bytes enter at the top and drift down toward bit 0.
                        word <= {byte_data, word[23:8]};
                        bcnt <= bcnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (bcnt == 2'd3) begin
                            mem_addr <= 32'({idx, 2'b00});
                            mem_din  <= {byte_data, word};
                        end
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) idx <= idx + {{(CNT_W-1){1'b0}}, 1'b1};
            if (state_nxt == S_IDLE && (state == S_CHECK || state == S_FINISH)) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table of whole-stream loads plus hand sequences
// for timing, producer gaps, async reset mid-load, the MAX_WORDS boundary and the optional checksum.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write log and done/cpu_rst edge monitor, sampled mid-cycle.
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic        done_q = 1'b0;
    logic        cpu_rst_q = 1'b0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
        end
        if (done === 1'b1 && done_q === 1'b0)
            check("cpu_rst_drop_with_done", {30'd0, cpu_rst_q, cpu_rst}, 32'h2);
        done_q    = done;
        cpu_rst_q = cpu_rst;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte 0x%0h not accepted", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(c);
`endif
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy === 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still 1", name);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        int          nb;      // stream bytes, right-aligned in s, first byte leftmost
        logic [79:0] s;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        edone;
        logic        eerr;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int k, input vec_t v);
        logic [7:0] b;
        logic [7:0] cs = 8'h00;
        wa.delete();
        wd.delete();
        pulse_start();
        check($sformatf("v%0d_cpu_rst_after_start", k), {31'd0, cpu_rst}, 32'd1);
        check($sformatf("v%0d_busy_after_start", k), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_flags_cleared", k), {30'd0, done, err}, 32'd0);
        for (int i = 0; i < v.nb; i++) begin
            b = v.s[8*(v.nb-1-i) +: 8];
            if (i >= 2) cs = cs ^ b;
            send_byte(b);
        end
        if (v.nw > 0 && !v.eerr) send_csum(cs);
        byte_valid = 1'b0;
        wait_idle($sformatf("v%0d", k));
        check($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, v.edone});
        check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.eerr});
        check($sformatf("v%0d_cpu_rst", k), {31'd0, cpu_rst}, {31'd0, v.eerr});
        check($sformatf("v%0d_byte_ready", k), {31'd0, byte_ready}, 32'd0);
        check($sformatf("v%0d_nwrites", k), wa.size(), v.nw);
        if (v.nw > 0 && wa.size() > 0) begin
            check($sformatf("v%0d_addr0", k), wa[0], 32'h0);
            check($sformatf("v%0d_din0", k), wd[0], v.w0);
        end
        if (v.nw > 1 && wa.size() > 1) begin
            check($sformatf("v%0d_addr1", k), wa[1], 32'h4);
            check($sformatf("v%0d_din1", k), wd[1], v.w1);
            check($sformatf("v%0d_din_hold", k), mem_din, v.w1);
            check($sformatf("v%0d_addr_hold", k), mem_addr, 32'h4);
        end
    endtask

    initial begin
        int         bad_addr;
        logic [7:0] kb;

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {24'd0, byte_ready, mem_we, cpu_rst, busy, done, err, 2'b00}, 32'd0);
        check("reset_addr", mem_addr, 32'h0);
        check("reset_din", mem_din, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

        vecs[0] = '{10, 80'h02_00_13_00_00_00_6F_00_00_00, 2, 32'h00000013, 32'h0000006F, 1'b1, 1'b0};
        vecs[1] = '{2,  80'h00_00,                           0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[2] = '{2,  80'h01_01,                           0, 32'h0,        32'h0,        1'b0, 1'b1};
        vecs[3] = '{6,  80'h01_00_13_00_00_00,               1, 32'h00000013, 32'h0,        1'b1, 1'b0};
        vecs[4] = '{6,  80'h01_00_AA_BB_CC_DD,               1, 32'hDDCCBBAA, 32'h0,        1'b1, 1'b0};
        vecs[5] = '{10, 80'h02_00_78_56_34_12_EF_BE_AD_DE, 2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[6] = '{2,  80'h01_01,                           0, 32'h0,        32'h0,        1'b0, 1'b1};
        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Zero length: done two cycles after LEN_HI is accepted.
        wa.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid = 1'b0;
        check("zero_len_done_not_yet", {30'd0, done, cpu_rst}, 32'h1);
        @(negedge clk);
        check("zero_len_done", {30'd0, done, cpu_rst}, 32'h2);
        check("zero_len_no_writes", wa.size(), 0);

        // Producer gaps plus a start pulse while busy.
        wa.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int j = 0; j < 4; j++) begin
            kb = 8'hAA + 8'(j * 17);
            send_byte(kb);
            byte_valid = 1'b0;
            byte_data  = 8'h55;
            if (j == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        send_csum(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
        byte_valid = 1'b0;
        wait_idle("gaps");
        check("gaps_nwrites", wa.size(), 1);
        if (wa.size() > 0) begin
            check("gaps_din", wd[0], 32'hDDCCBBAA);
            check("gaps_addr", wa[0], 32'h0);
        end
        check("gaps_done", {30'd0, done, err}, 32'h2);

        // Async reset during the third data byte of a 4-word load.
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        wa.delete();
        #2 rst = 1'b1;
        #1;
        check("async_rst_flags",
              {24'd0, byte_ready, mem_we, cpu_rst, busy, done, err, 2'b00}, 32'd0);
        check("async_rst_addr", mem_addr, 32'h0);
        check("async_rst_din", mem_din, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check("post_rst_no_writes", wa.size(), 0);
        check("post_rst_idle", {29'd0, byte_ready, cpu_rst, busy}, 32'd0);

        // MAX_WORDS is legal: 256 words, word k = {k,k,k,k}.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            for (int j = 0; j < 4; j++) send_byte(kb);
        end
        send_csum(8'h00);
        byte_valid = 1'b0;
        wait_idle("max");
        check("max_done", {30'd0, done, err}, 32'h2);
        check("max_nwrites", wa.size(), 256);
        bad_addr = 0;
        for (int k = 0; k < wa.size(); k++) if (wa[k] !== 32'(k * 4)) bad_addr++;
        check("max_addr_sequence", bad_addr, 0);
        if (wd.size() == 256) check("max_last_din", wd[255], 32'hFFFFFFFF);

`ifdef INST_LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        byte_valid = 1'b0;
        wait_idle("csum_ok");
        check("csum_ok", {29'd0, done, err, cpu_rst}, 32'h4);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        byte_valid = 1'b0;
        wait_idle("csum_bad");
        check("csum_bad", {29'd0, done, err, cpu_rst}, 32'h3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
